// File: rtl/scan_mux.sv
// Registered channel multiplexer with manual select and auto-scan with per-channel dwell.
// Optional even-parity output y_par is built when SCAN_MUX_PARITY_EN is defined.
module scan_mux #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CH    = 8,
    parameter int unsigned SELW  = 3,
    parameter int unsigned DWW   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH*WIDTH-1:0]   d,
    input  logic [SELW-1:0]       sel,
    input  logic                  mode,
    input  logic                  en,
    input  logic [DWW-1:0]        dwell,
    output logic [WIDTH-1:0]      y,
    output logic [SELW-1:0]       y_ch,
    output logic                  y_valid,
`ifdef SCAN_MUX_PARITY_EN
    output logic                  y_par,
`endif
    output logic                  wrap
);

    localparam logic [SELW-1:0] LastCh = SELW'(CH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StManual,
        StScan
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  y_q;
    logic [SELW-1:0]   y_ch_q;
    logic              y_valid_q;
    logic              wrap_q;
    logic [SELW-1:0]   ptr_q;
    logic [DWW-1:0]    cnt_q;
`ifdef SCAN_MUX_PARITY_EN
    logic              y_par_q;
`endif

    logic [WIDTH-1:0]  sel_data;
    logic [WIDTH-1:0]  ptr_data;
    logic [WIDTH-1:0]  man_data;
    logic [WIDTH-1:0]  load_data;
    logic              sel_ok;
    logic              wrap_hit;
    logic              advance;
    logic [SELW-1:0]   ptr_next;

    always_comb begin
        unique case ({en, mode})
            2'b10:   state_d = StManual;
            2'b11:   state_d = StScan;
            default: state_d = StIdle;
        endcase
    end

    // Explicit compare loops keep out-of-range selects from indexing past d.
    always_comb begin
        sel_data = '0;
        ptr_data = '0;
        for (int k = 0; k < int'(CH); k++) begin
            if (sel == SELW'(k)) begin
                sel_data = d[k*WIDTH +: WIDTH];
            end
            if (ptr_q == SELW'(k)) begin
                ptr_data = d[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        sel_ok    = 32'(sel) < CH;
        man_data  = sel_ok ? sel_data : '0;
        load_data = (state_d == StScan) ? ptr_data : man_data;
        advance   = cnt_q >= dwell;
        ptr_next  = (ptr_q == LastCh) ? '0 : ptr_q + 1'b1;
        // ptr_q is forced to 0 outside SCAN, so only a real CH-1 -> 0 step can match.
        wrap_hit  = (state_q == StScan) && (ptr_q == '0) && (y_ch_q == LastCh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            y_q       <= '0;
            y_ch_q    <= '0;
            y_valid_q <= 1'b0;
            wrap_q    <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
`ifdef SCAN_MUX_PARITY_EN
            y_par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            unique case (state_d)
                StManual: begin
                    y_q       <= load_data;
                    y_ch_q    <= sel;
                    y_valid_q <= sel_ok;
                    wrap_q    <= 1'b0;
                    ptr_q     <= '0;
                    cnt_q     <= '0;
`ifdef SCAN_MUX_PARITY_EN
                    y_par_q   <= ^load_data;
`endif
                end
                StScan: begin
                    y_q       <= load_data;
                    y_ch_q    <= ptr_q;
                    y_valid_q <= 1'b1;
                    wrap_q    <= wrap_hit;
`ifdef SCAN_MUX_PARITY_EN
                    y_par_q   <= ^load_data;
`endif
                    if (advance) begin
                        ptr_q <= ptr_next;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    y_valid_q <= 1'b0;
                    wrap_q    <= 1'b0;
                    ptr_q     <= '0;
                    cnt_q     <= '0;
                end
            endcase
        end
    end

    assign y       = y_q;
    assign y_ch    = y_ch_q;
    assign y_valid = y_valid_q;
    assign wrap    = wrap_q;
`ifdef SCAN_MUX_PARITY_EN
    assign y_par   = y_par_q;
`endif

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel.
REQ-002 Parameter CH, default 8, number of input channels; legal range 2..2^SELW.
REQ-003 Parameter SELW, default 3, select/channel-index width.
REQ-004 Parameter DWW, default 4, dwell-count width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 d  input  CH*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 sel  input  SELW  manual channel select.
REQ-009 mode  input  1  0 = manual select, 1 = auto-scan.
REQ-010 en  input  1  block enable.
REQ-011 dwell  input  DWW  extra cycles each channel is held in auto-scan.
REQ-012 y  output  WIDTH  registered selected data.
REQ-013 y_ch  output  SELW  channel index that produced y.
REQ-014 y_valid  output  1  y/y_ch hold a valid sample this cycle.
REQ-015 wrap  output  1  one-cycle pulse on scan wrap-around.

Function
REQ-016 The block SHALL implement three states: IDLE (en=0), MANUAL (en=1, mode=0) and SCAN (en=1, mode=1); the next state is decoded from en/mode on every edge.
REQ-017 IDLE: y and y_ch SHALL hold, y_valid=0, wrap=0.
REQ-018 MANUAL: with sel<CH, y<=d[sel], y_ch<=sel, y_valid<=1, with 1-cycle latency from sel/d to y.
REQ-019 MANUAL: with sel>=CH, y<=0, y_ch<=sel, y_valid<=0.
REQ-020 SCAN: the block SHALL keep pointer ptr and dwell counter cnt; each edge it loads y<=d[ptr], y_ch<=ptr, y_valid<=1.
REQ-021 SCAN: when cnt>=dwell, ptr SHALL advance and cnt clears to 0; otherwise cnt increments.
REQ-022 Each channel SHALL appear for dwell+1 consecutive cycles; dwell=0 advances every cycle.
REQ-023 ptr SHALL wrap from CH-1 to 0, never visiting indices >= CH.
REQ-024 wrap SHALL be 1 for exactly the one cycle in which y_ch first shows channel 0 after channel CH-1 in SCAN; otherwise 0.
REQ-025 Entry into SCAN from IDLE or MANUAL SHALL restart with ptr=0, cnt=0, so the first SCAN output is channel 0 with wrap=0.
REQ-026 Leaving SCAN (en or mode change) SHALL take effect on the next edge; the scan position is not retained.
REQ-027 A dwell change mid-hold SHALL apply immediately through the >= compare; if cnt already exceeds the new dwell, ptr advances on the next edge.
REQ-028 d changes during a hold SHALL be tracked: y reflects d[ptr] sampled on every edge, not only the first.

Reset
REQ-029 While rst_n=0, and immediately on its assertion regardless of clk: y=0, y_ch=0, y_valid=0, wrap=0 (and y_par=0 when present), state IDLE, ptr=0, cnt=0.
REQ-030 Reset asserted mid-scan SHALL abort the scan; after release, operation starts from REQ-025 conditions.

Configuration
REQ-031 Macro SCAN_MUX_PARITY_EN defined: the block SHALL add output y_par (1 bit), the registered even parity (XOR) of the value loaded into y, updated on the same edge as y and held in IDLE.
REQ-032 Macro SCAN_MUX_PARITY_EN undefined: the y_par port and its logic SHALL be absent; all other behaviour is unchanged.

Verification (WIDTH=8, CH=8, SELW=3, DWW=4)
REQ-033 Manual: en=1, mode=0, d[k]=8'h10+k, sel=5 -> next cycle y=8'h15, y_ch=5, y_valid=1.
REQ-034 Bad select: CH=6, sel=7 in MANUAL -> y=0, y_ch=7, y_valid=0.
REQ-035 Scan: dwell=2, mode=1 -> y_ch sequence 0,0,0,1,1,1,...,7,7,7,0, with wrap=1 only on the first 0 after 7.
REQ-036 Dwell shrink: dwell=9, switched to 1 when cnt=5 -> ptr advances on the next edge, then holds 2 cycles per channel.
REQ-037 Reset mid-scan: rst_n pulled low asynchronously at y_ch=4 -> all outputs 0 at once; after release with en=1, mode=1, the first sample is channel 0.
REQ-038 Parity (macro defined): MANUAL, d[2]=8'h07, sel=2 -> y=8'h07, y_par=1.
